axis_stream_gen: RTL and testbench
==================================

# axis_stream_gen

Single-clock AXI4-Stream master that generates packetized test traffic into the slave side of the AXIS data FIFO. On a start request it emits a programmed number of packets of programmed length, with a deterministic data pattern and `tlast` on each packet's final beat. It fully honours `tready` backpressure. It is the transmitter counterpart to the stream consumer and is used for FIFO bring-up and throughput checks.

## Interface
- `DATA_WIDTH`, 32, width of `m_axis_tdata`.
- `LEN_WIDTH`, 16, width of the packet-length and packet-count inputs.

Ports:
- `axis_clk`  in  1  clock; all logic is rising-edge.
- `axis_rst`  in  1  reset; asynchronous, active-high.
- `start`  in  1  launch request; sampled only in IDLE.
- `pkt_len`  in  LEN_WIDTH  beats per packet; latched on start.
- `pkt_num`  in  LEN_WIDTH  packets per run; latched on start.
- `seed`  in  DATA_WIDTH  first data value of the run; latched on start.
- `busy`  out  1  high in SEND.
- `done`  out  1  one-cycle pulse at the end of a run.
- `sent_cnt`  out  32  beats accepted since the last start.
- `m_axis_tvalid`  out  1  beat valid.
- `m_axis_tready`  in  1  sink ready.
- `m_axis_tdata`  out  DATA_WIDTH  beat data.
- `m_axis_tlast`  out  1  last beat of a packet.

## Operation
- The FSM has three states: IDLE, SEND, DONE.
- IDLE to SEND: `start`=1 with `pkt_len`≠0 and `pkt_num`≠0.
  - Latch `pkt_len`, `pkt_num` and `seed`.
  - Clear `sent_cnt`, the beat counter and the packet counter.
- IDLE to DONE: `start`=1 with `pkt_len`=0 or `pkt_num`=0. No beats are sent, and `sent_cnt` clears to 0.
- SEND:
  - `m_axis_tvalid`=1 and `m_axis_tdata` = current pattern value.
  - `m_axis_tlast`=1 when the beat counter equals `pkt_len`-1.
- Handshake: a beat is accepted when `tvalid && tready` at a rising edge. On acceptance:
  - the pattern advances;
  - `sent_cnt` increments and wraps at 2^32;
  - the beat counter increments, or resets to 0 after the tlast beat, which also increments the packet counter.
- SEND to DONE: acceptance of the tlast beat of packet `pkt_num`-1.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- Pattern (default): a counter starting at `seed`, +1 per accepted beat, wrapping from 2^DATA_WIDTH-1 to 0. It continues across packet boundaries and does not restart per packet.
- `start` in SEND or DONE is ignored. It is not queued.
- Registered outputs: `tvalid`, `tdata` and `tlast` never depend combinationally on `tready`.

## Timing
- Reset values: `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0, `busy`=0, `done`=0, `sent_cnt`=0, state IDLE.
- Reset asserted mid-run: the outputs above take effect immediately. The run is abandoned, and no `done` is issued.
- Start latency: `start` high at edge N gives `tvalid`=1 and `busy`=1 from edge N, so the first beat is presentable in cycle N+1.
- Zero-length start: `done`=1 in the cycle after edge N.
- Stall: while `tvalid`=1 and `tready`=0, `tdata` and `tlast` hold stable and `tvalid` stays high.
- Throughput: one beat per cycle while `tready`=1, including across packet boundaries.
- End of run: the final acceptance at edge M gives `tvalid`=0, `tlast`=0 and `done`=1 in cycle M+1, and `busy`=0 from edge M.
  - A new `start` is accepted at edge M+2 at the earliest (IDLE).
- `pkt_len`=1: every beat has `tlast`=1.

## Configuration
- `AXIS_STREAM_GEN_LFSR_EN` defined:
  - The pattern is a 32-bit Galois LFSR with polynomial 0x80200003, initialised from `seed`.
  - A zero seed is replaced with 32'h1.
  - Each accepted beat advances the LFSR one step: shift right, then XOR the polynomial when the output bit is 1.
  - `DATA_WIDTH` must be 32.
- Undefined: the counting pattern described above.

## Test plan
- Counting run with `seed`=0, `pkt_len`=4, `pkt_num`=3 and `tready` tied 1:
  - data 0..11, with tlast on beats 3, 7 and 11;
  - 12 consecutive valid cycles;
  - `done` pulses once and `sent_cnt`=12.
- Backpressure with `tready` toggling 1,0,0,1 repeating, `pkt_len`=5, `pkt_num`=2: each beat is held stable through the stalls, the sink receives 0..9 in order, and tlast falls on beats 4 and 9.
- Wrap-around with `seed`=32'hFFFF_FFFE, `pkt_len`=4, `pkt_num`=1: data FFFF_FFFE, FFFF_FFFF, 0, 1, with tlast on value 1.
- Zero length with `pkt_len`=0, `pkt_num`=7:
  - `tvalid` never rises;
  - `done`=1 in the cycle after start;
  - `sent_cnt`=0.
- Reset mid-run: assert `axis_rst` after 3 accepted beats of a 10-beat packet.
  - `tvalid`, `busy` and `sent_cnt` go to 0 immediately, with no `done`.
  - A new start after reset release replays from `seed`.
- With `AXIS_STREAM_GEN_LFSR_EN` and `seed`=0:
  - the first beat is 32'h0000_0001 (the zero seed is replaced with 32'h1);
  - the second beat is 32'h8020_0003;
  - a `start` pulsed during SEND is ignored.

Source files
------------

// File: rtl/axis_stream_gen.sv
// AXI4-Stream packet traffic generator: emits pkt_num packets of pkt_len beats with a
// counting pattern, or a Galois LFSR pattern when AXIS_STREAM_GEN_LFSR_EN is defined.
module axis_stream_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  axis_clk,
  input  logic                  axis_rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  pkt_len,
  input  logic [LEN_WIDTH-1:0]  pkt_num,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           sent_cnt,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast
);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_DONE} state_t;

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  state_t               state, state_nxt;
  logic [LEN_WIDTH-1:0] len_q, num_q, beat_cnt, pkt_cnt;
  logic [LEN_WIDTH-1:0] beat_nxt, len_m1, num_m1;
  logic                 launch, accept, beat_last, pkt_last;

  function automatic logic [DATA_WIDTH-1:0] pattern_init(input logic [DATA_WIDTH-1:0] s);
`ifdef AXIS_STREAM_GEN_LFSR_EN
    // An all-zero LFSR state would lock up, so substitute 1.
    pattern_init = (s == '0) ? DATA_WIDTH'(1) : s;
`else
    pattern_init = s;
`endif
  endfunction

  function automatic logic [DATA_WIDTH-1:0] pattern_step(input logic [DATA_WIDTH-1:0] d);
`ifdef AXIS_STREAM_GEN_LFSR_EN
    pattern_step = d[0] ? ((d >> 1) ^ DATA_WIDTH'(32'h8020_0003)) : (d >> 1);
`else
    pattern_step = d + DATA_WIDTH'(1);
`endif
  endfunction

  assign launch    = start && (pkt_len != '0) && (pkt_num != '0);
  assign accept    = m_axis_tvalid && m_axis_tready;
  assign beat_nxt  = beat_cnt + LEN_ONE;
  assign len_m1    = len_q - LEN_ONE;
  assign num_m1    = num_q - LEN_ONE;
  assign beat_last = (beat_cnt == len_m1);
  assign pkt_last  = (pkt_cnt == num_m1);

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = launch ? ST_SEND : ST_DONE;
      ST_SEND: if (accept && beat_last && pkt_last) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // All stream outputs are registered so nothing depends combinationally on tready.
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      sent_cnt      <= '0;
      len_q         <= '0;
      num_q         <= '0;
      beat_cnt      <= '0;
      pkt_cnt       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            len_q    <= pkt_len;
            num_q    <= pkt_num;
            sent_cnt <= '0;
            beat_cnt <= '0;
            pkt_cnt  <= '0;
            if (launch) begin
              m_axis_tvalid <= 1'b1;
              m_axis_tdata  <= pattern_init(seed);
              m_axis_tlast  <= (pkt_len == LEN_ONE);
              busy          <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ST_SEND: begin
          if (accept) begin
            m_axis_tdata <= pattern_step(m_axis_tdata);
            sent_cnt     <= sent_cnt + 32'd1;
            if (beat_last) begin
              beat_cnt <= '0;
              pkt_cnt  <= pkt_cnt + LEN_ONE;
              if (pkt_last) begin
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
                busy          <= 1'b0;
                done          <= 1'b1;
              end else begin
                m_axis_tlast <= (len_q == LEN_ONE);
              end
            end else begin
              beat_cnt     <= beat_nxt;
              m_axis_tlast <= (beat_nxt == len_m1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_stream_gen.sv
// Self-checking bench for axis_stream_gen: scoreboard of expected beats plus directed
// literal checks; LFSR expectations apply when AXIS_STREAM_GEN_LFSR_EN is defined.
module tb_axis_stream_gen;

  logic        axis_clk;
  logic        axis_rst;
  logic        start;
  logic [15:0] pkt_len;
  logic [15:0] pkt_num;
  logic [31:0] seed;
  logic        busy;
  logic        done;
  logic [31:0] sent_cnt;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tlast;

  axis_stream_gen #(.DATA_WIDTH(32), .LEN_WIDTH(16)) dut (
    .axis_clk      (axis_clk),
    .axis_rst      (axis_rst),
    .start         (start),
    .pkt_len       (pkt_len),
    .pkt_num       (pkt_num),
    .seed          (seed),
    .busy          (busy),
    .done          (done),
    .sent_cnt      (sent_cnt),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast)
  );

  initial axis_clk = 1'b0;
  always #5 axis_clk = ~axis_clk;

  int          checks   = 0;
  int          failures = 0;
  logic [32:0] exp_q[$];
  logic [32:0] rx_q[$];
  int          run_id   = 0;
  int          seen_id  = 0;
  int          acc_cnt  = 0;
  int          vld_cnt  = 0;
  int          done_seen = 0;
  bit          mon_en   = 1'b0;
  bit          prev_stall = 1'b0;
  bit          prev_done  = 1'b0;
  logic [31:0] prev_data;
  logic        prev_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] m_init(input logic [31:0] s);
`ifdef AXIS_STREAM_GEN_LFSR_EN
    return (s == 32'd0) ? 32'd1 : s;
`else
    return s;
`endif
  endfunction

  function automatic logic [31:0] m_step(input logic [31:0] d);
`ifdef AXIS_STREAM_GEN_LFSR_EN
    return d[0] ? ((d >> 1) ^ 32'h8020_0003) : (d >> 1);
`else
    return d + 32'd1;
`endif
  endfunction

  // Compare process: every beat the sink takes must match the head of the model queue.
  always @(negedge axis_clk) begin
    if (!mon_en || axis_rst) begin
      prev_stall = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (run_id != seen_id) begin
        seen_id = run_id;
        acc_cnt = 0;
        vld_cnt = 0;
        rx_q.delete();
      end else begin
        chk("sent_cnt", sent_cnt, acc_cnt);
      end
      chk("busy_eq_valid", busy, m_axis_tvalid);
      if (prev_stall)
        chk("stall_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b1, prev_last, prev_data});
      if (m_axis_tvalid) vld_cnt++;
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", {m_axis_tlast, m_axis_tdata}, 33'h0);
          chk("extra_beat_cnt", 1, 0);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          chk("beat", {m_axis_tlast, m_axis_tdata}, e);
        end
        rx_q.push_back({m_axis_tlast, m_axis_tdata});
        acc_cnt++;
      end
      if (done) begin
        done_seen++;
        chk("done_pending", exp_q.size(), 0);
        chk("done_width", prev_done, 0);
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
      prev_done  = done;
    end
  end

  task automatic start_run(input logic [31:0] s, input int len, input int num);
    logic [31:0] d;
    seed    = s;
    pkt_len = 16'(len);
    pkt_num = 16'(num);
    start   = 1'b1;
    d = m_init(s);
    for (int i = 0; i < len * num; i++) begin
      exp_q.push_back({(i % len) == len - 1, d});
      d = m_step(d);
    end
    run_id++;
    @(posedge axis_clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int mode, input bit inject);
    int d0;
    d0 = done_seen;
    for (int i = 0; i < 400; i++) begin
      m_axis_tready = (mode == 1) ? ((i % 4 == 0) || (i % 4 == 3)) : 1'b1;
      if (inject && i == 5) begin
        start = 1'b1; pkt_len = 16'd2; pkt_num = 16'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge axis_clk); #1;
      if (done_seen != d0) break;
    end
    start = 1'b0;
    m_axis_tready = 1'b1;
    chk("run_done", done_seen - d0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    axis_rst = 1'b1; start = 1'b0; pkt_len = '0; pkt_num = '0; seed = '0;
    m_axis_tready = 1'b0;
    repeat (3) @(posedge axis_clk);
    #1;
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sent", sent_cnt, 0);
    axis_rst = 1'b0;
    m_axis_tready = 1'b1;
    mon_en = 1'b1;
    @(posedge axis_clk); #1;

    // Counting run, tready high, with an ignored start mid-run.
    start_run(32'd0, 4, 3);
    wait_done(0, 1'b1);
    chk("t1_vld_cycles", vld_cnt, 12);
    chk("t1_sent", sent_cnt, 12);
`ifndef AXIS_STREAM_GEN_LFSR_EN
    chk("t1_rx_n", rx_q.size(), 12);
    for (int k = 0; k < 12; k++)
      chk("t1_rx", rx_q[k], {(k % 4) == 3, 32'(k)});
`endif
    for (int k = 0; k < 3; k++) begin
      @(posedge axis_clk); #1;
      chk("t1_no_requeue", {m_axis_tvalid, busy}, 2'b00);
    end

    // Backpressure 1,0,0,1.
    start_run(32'd0, 5, 2);
    wait_done(1, 1'b0);
    chk("t2_sent", sent_cnt, 10);
`ifndef AXIS_STREAM_GEN_LFSR_EN
    chk("t2_rx_n", rx_q.size(), 10);
    for (int k = 0; k < 10; k++)
      chk("t2_rx", rx_q[k], {(k == 4) || (k == 9), 32'(k)});
`endif
    @(posedge axis_clk); #1;

    // Wrap-around.
    start_run(32'hFFFF_FFFE, 4, 1);
    wait_done(0, 1'b0);
`ifndef AXIS_STREAM_GEN_LFSR_EN
    chk("t3_rx0", rx_q[0], {1'b0, 32'hFFFF_FFFE});
    chk("t3_rx1", rx_q[1], {1'b0, 32'hFFFF_FFFF});
    chk("t3_rx2", rx_q[2], {1'b0, 32'h0000_0000});
    chk("t3_rx3", rx_q[3], {1'b1, 32'h0000_0001});
`endif
    @(posedge axis_clk); #1;

    // Zero length.
    start_run(32'd5, 0, 7);
    chk("t4_done", done, 1);
    chk("t4_tvalid", m_axis_tvalid, 0);
    chk("t4_sent", sent_cnt, 0);
    @(posedge axis_clk); #1;
    chk("t4_done_fall", done, 0);
    chk("t4_tvalid2", m_axis_tvalid, 0);
    @(posedge axis_clk); #1;

    // Reset mid-run, then replay.
    start_run(32'h100, 10, 1);
    for (int i = 0; i < 50 && sent_cnt != 32'd3; i++) begin
      @(posedge axis_clk); #1;
    end
    chk("t5_pre_sent", sent_cnt, 3);
    mon_en = 1'b0;
    axis_rst = 1'b1;
    #1;
    chk("t5_rst_now", {m_axis_tvalid, busy, done, m_axis_tlast, sent_cnt}, 36'h0);
    for (int k = 0; k < 2; k++) begin
      @(posedge axis_clk); #1;
      chk("t5_rst_hold", {m_axis_tvalid, busy, done}, 3'b000);
    end
    axis_rst = 1'b0;
    @(posedge axis_clk); #1;
    chk("t5_no_done", {done, m_axis_tvalid}, 2'b00);
    exp_q.delete();
    mon_en = 1'b1;
    start_run(32'h100, 10, 1);
    wait_done(0, 1'b0);
    chk("t5_replay_sent", sent_cnt, 10);
`ifndef AXIS_STREAM_GEN_LFSR_EN
    chk("t5_replay_rx0", rx_q[0], {1'b0, 32'h100});
    chk("t5_replay_rx9", rx_q[9], {1'b1, 32'h109});
`endif
    @(posedge axis_clk); #1;

`ifdef AXIS_STREAM_GEN_LFSR_EN
    // LFSR with zero seed.
    start_run(32'd0, 4, 1);
    wait_done(0, 1'b1);
    chk("t6_rx0", rx_q[0], {1'b0, 32'h0000_0001});
    chk("t6_rx1", rx_q[1], {1'b0, 32'h8020_0003});
    @(posedge axis_clk); #1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
